// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction cache: word width, NOP encoding and miss-FSM states.
package icache_ctrl_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STATE_W = 2;

  // addi x0, x0, 0
  localparam logic [WORD_W-1:0] ISA_NOP = 32'h0000_0013;

  typedef enum logic [STATE_W-1:0] {
    ICACHE_IDLE  = 2'd0,
    ICACHE_FETCH = 2'd1,
    ICACHE_FILL  = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_ram.sv
// Tag+data line array: combinational read port for lookup, synchronous write port for refill.
module icache_ram
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned LINES   = 16,
  parameter int unsigned INDEX_W = $clog2(LINES),
  parameter int unsigned TAG_W   = 28
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] raddr_i,
  output logic [TAG_W-1:0]   rtag_o,
  output logic [WORD_W-1:0]  rdata_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] waddr_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  logic [WORD_W-1:0]  wdata_i
);

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES];

  // Contents are qualified by the valid bits in the controller, so no reset here.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[waddr_i]  <= wtag_i;
      data_q[waddr_i] <= wdata_i;
    end
  end

  assign rtag_o  = tag_q[raddr_i];
  assign rdata_o = data_q[raddr_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache with a req/ack refill FSM.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned LINES   = 16,
  parameter int unsigned INDEX_W = $clog2(LINES),
  parameter int unsigned TAG_W   = 32 - INDEX_W - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] pc,
  input  logic              en,
  input  logic              inval,
  output logic [WORD_W-1:0] insn,
  output logic              stall,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int unsigned WADDR_W = WORD_W - 2;

  icache_state_e      state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               mem_req_q, mem_req_d;
  logic [WADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic               drop_q, drop_d;

  logic [INDEX_W-1:0] idx_c;
  logic [TAG_W-1:0]   tag_c;
  logic [TAG_W-1:0]   rd_tag;
  logic [WORD_W-1:0]  rd_data;
  logic               hit_c;
  logic               ram_we_c;
  logic               unused_pc_bits;

  assign idx_c          = pc[INDEX_W+1:2];
  assign tag_c          = pc[WORD_W-1:INDEX_W+2];
  assign unused_pc_bits = ^pc[1:0];

  // Fill index/tag come from the registered word address, not the live pc.
  icache_ram #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_ram (
    .clk     (clk),
    .raddr_i (idx_c),
    .rtag_o  (rd_tag),
    .rdata_o (rd_data),
    .we_i    (ram_we_c),
    .waddr_i (mem_addr_q[INDEX_W-1:0]),
    .wtag_i  (mem_addr_q[WADDR_W-1:INDEX_W]),
    .wdata_i (mem_rdata)
  );

  assign hit_c = en && valid_q[idx_c] && (rd_tag == tag_c) && (state_q == ICACHE_IDLE);

  always_comb begin
    stall = (state_q == ICACHE_IDLE) ? (en && !hit_c) : 1'b1;
    insn  = hit_c ? rd_data : ISA_NOP;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = {mem_addr_q, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ICACHE_IDLE;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    drop_d     = drop_q;
    ram_we_c   = 1'b0;

    unique case (state_q)
      ICACHE_IDLE: begin
        if (en && !hit_c) begin
          state_d    = ICACHE_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc[WORD_W-1:2];
        end
      end
      ICACHE_FETCH: begin
        if (inval) drop_d = 1'b1;
        if (mem_ack) begin
          ram_we_c                          = 1'b1;
          valid_d[mem_addr_q[INDEX_W-1:0]]  = !drop_q;
          mem_req_d                         = 1'b0;
          state_d                           = ICACHE_FILL;
        end
      end
      ICACHE_FILL: begin
        state_d = ICACHE_IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = ICACHE_IDLE;
    endcase

    // Invalidation wins over a fill landing in the same cycle.
    if (inval) valid_d = '0;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: scoreboarded fetches against a bench-side memory model.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        en;
  logic        inval;
  logic [31:0] insn;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q[$];

  icache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .en        (en),
    .inval     (inval),
    .insn      (insn),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[23:0], 8'h93};
    if (a == 32'h0000_0100) w = 32'h00A0_0093;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard and compares against the live insn output.
  task automatic pop_insn(input string name);
    logic [31:0] exp_w;
    vec_cnt++;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s: scoreboard empty, insn=%h", name, insn);
    end else begin
      exp_w = exp_q.pop_front();
      if (insn !== exp_w || stall !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s: insn=%h stall=%b, required insn=%h stall=0", name, insn, stall, exp_w);
      end
    end
  endtask

  // Entered in the first FETCH cycle; acks after dly cycles, returns in the IDLE cycle after FILL.
  task automatic serve_refill(input logic [31:0] a, input int dly, input bit inv_at_ack);
    for (int k = 0; k <= dly; k++) begin
      vec_cnt++;
      if (mem_req !== 1'b1 || mem_addr !== a || stall !== 1'b1 || insn !== ISA_NOP) begin
        err_cnt++;
        $display("FAIL fetch_hold[%0d]: req=%b addr=%h stall=%b insn=%h, required req=1 addr=%h stall=1 insn=%h",
                 k, mem_req, mem_addr, stall, insn, a, ISA_NOP);
      end
      if (k == dly) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(a);
        inval     = inv_at_ack;
      end
      step();
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    inval     = 1'b0;
    #1;
    vec_cnt++;
    if (mem_req !== 1'b0 || stall !== 1'b1) begin
      err_cnt++;
      $display("FAIL fill_cycle: req=%b stall=%b, required req=0 stall=1", mem_req, stall);
    end
    step();
  endtask

  task automatic fetch_miss(input logic [31:0] a, input int dly);
    pc = a;
    en = 1'b1;
    #1;
    exp_q.push_back(mem_word(a));
    vec_cnt++;
    if (stall !== 1'b1 || insn !== ISA_NOP || mem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL miss_detect %h: stall=%b insn=%h req=%b, required stall=1 insn=%h req=0",
               a, stall, insn, mem_req, ISA_NOP);
    end
    step();
    serve_refill(a, dly, 1'b0);
    pop_insn("miss_result");
    step();
  endtask

  task automatic fetch_hit(input logic [31:0] a);
    pc = a;
    en = 1'b1;
    #1;
    exp_q.push_back(mem_word(a));
    pop_insn("hit_result");
    step();
    vec_cnt++;
    if (mem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL hit_no_req %h: req=%b, required 0", a, mem_req);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    pc        = 32'h0;
    en        = 1'b0;
    inval     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    step();
    step();
    reset = 1'b1;
    step();
    vec_cnt++;
    if (stall !== 1'b0 || insn !== ISA_NOP) begin
      err_cnt++;
      $display("FAIL reset_out: stall=%b insn=%h, required stall=0 insn=%h", stall, insn, ISA_NOP);
    end
    vec_cnt++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_bus: req=%b addr=%h, required req=0 addr=0", mem_req, mem_addr);
    end
  endtask

  task automatic test_miss_refill();
    fetch_miss(32'h0000_0100, 3);
  endtask

  task automatic test_hit();
    fetch_hit(32'h0000_0100);
  endtask

  task automatic test_conflict();
    fetch_miss(32'h0000_0140, 1);
    fetch_miss(32'h0000_0100, 0);
    fetch_hit(32'h0000_0100);
  endtask

  task automatic test_inval_hit();
    pc    = 32'h0000_0100;
    en    = 1'b1;
    inval = 1'b1;
    #1;
    exp_q.push_back(mem_word(32'h0000_0100));
    pop_insn("inval_hit_same_cycle");
    step();
    inval = 1'b0;
    #1;
    vec_cnt++;
    if (stall !== 1'b1 || insn !== ISA_NOP) begin
      err_cnt++;
      $display("FAIL inval_hit_next: stall=%b insn=%h, required stall=1 insn=%h", stall, insn, ISA_NOP);
    end
    step();
    serve_refill(32'h0000_0100, 1, 1'b0);
    exp_q.push_back(mem_word(32'h0000_0100));
    pop_insn("inval_hit_refill");
    step();
  endtask

  task automatic test_inval_at_ack();
    pc = 32'h0000_0200;
    en = 1'b1;
    #1;
    vec_cnt++;
    if (stall !== 1'b1) begin
      err_cnt++;
      $display("FAIL inval_ack_detect: stall=%b, required 1", stall);
    end
    step();
    serve_refill(32'h0000_0200, 2, 1'b1);
    vec_cnt++;
    if (stall !== 1'b1 || mem_req !== 1'b0 || insn !== ISA_NOP) begin
      err_cnt++;
      $display("FAIL inval_ack_remiss: stall=%b req=%b insn=%h, required stall=1 req=0 insn=%h",
               stall, mem_req, insn, ISA_NOP);
    end
    step();
    serve_refill(32'h0000_0200, 0, 1'b0);
    exp_q.push_back(mem_word(32'h0000_0200));
    pop_insn("inval_ack_refetch");
    step();
  endtask

  task automatic test_en_low();
    en = 1'b0;
    pc = 32'h0000_0200;
    #1;
    vec_cnt++;
    if (stall !== 1'b0 || insn !== ISA_NOP || mem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL en_low: stall=%b insn=%h req=%b, required stall=0 insn=%h req=0",
               stall, insn, mem_req, ISA_NOP);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    vec_cnt++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL spurious_ack: req=%b stall=%b, required req=0 stall=0", mem_req, stall);
    end
    en = 1'b1;
    #1;
    exp_q.push_back(mem_word(32'h0000_0200));
    pop_insn("after_spurious_ack");
    step();
  endtask

  task automatic test_reset_mid_fetch();
    fetch_miss(32'h0000_0104, 0);
    pc = 32'h0000_0108;
    en = 1'b1;
    #1;
    step();
    vec_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0108) begin
      err_cnt++;
      $display("FAIL pre_reset_fetch: req=%b addr=%h, required req=1 addr=00000108", mem_req, mem_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      err_cnt++;
      $display("FAIL async_reset: req=%b addr=%h, required req=0 addr=0", mem_req, mem_addr);
    end
    en = 1'b0;
    #1;
    vec_cnt++;
    if (stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state_idle: stall=%b, required 0", stall);
    end
    step();
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    vec_cnt++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL late_ack: req=%b stall=%b, required req=0 stall=0", mem_req, stall);
    end
    // Line 0x104 was valid before reset and must now miss.
    fetch_miss(32'h0000_0104, 1);
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hit();
    test_conflict();
    test_inval_hit();
    test_inval_at_ack();
    test_en_low();
    test_reset_mid_fetch();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
